apb_master_gen: RTL and testbench
=================================

Name: apb_master_gen

Overview:
- Parametrised APB4 master. Successor to the single-width 4-bit-address/16-bit-data APB master.
- Accepts commands on a valid/ready request channel and registers them before driving the APB bus. The bus is driven only from registers, never combinationally from the command inputs.
- Returns read data and error status on a one-cycle response pulse. Supports back-to-back transfers, byte strobes, pprot, pslverr and a programmable wait-state timeout.
- Sits between a local controller (CPU or DMA side) and the APB peripheral fabric.

Parameters:
- ADDR_W, 8, width of paddr and cmd_addr.
- DATA_W, 32, width of pwdata/prdata; must be a multiple of 8.
- TIMEOUT, 16, max consecutive ACCESS cycles with pready low before abort; 0 disables the timeout.

Ports:
- pclk  in  1  APB clock; all logic on rising edge.
- preset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_write  in  1  1=write, 0=read.
- cmd_addr  in  ADDR_W  transfer address.
- cmd_wdata  in  DATA_W  write data.
- cmd_strb  in  DATA_W/8  write byte strobes.
- cmd_prot  in  3  protection attributes.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  DATA_W  read data; 0 for writes and timeouts.
- rsp_err  out  1  pslverr or timeout on the completed transfer.
- rsp_timeout  out  1  completion was a timeout abort.
- psel  out  1  APB select.
- penable  out  1  APB enable.
- pwrite  out  1  APB direction.
- paddr  out  ADDR_W  APB address.
- pwdata  out  DATA_W  APB write data.
- pstrb  out  DATA_W/8  APB strobes.
- pprot  out  3  APB protection.
- pready  in  1  slave ready.
- prdata  in  DATA_W  slave read data.
- pslverr  in  1  slave error.

Behaviour:
- Reset (preset=1 at a pclk edge):
  - State goes to IDLE.
  - psel, penable, pwrite, paddr, pwdata, pstrb, pprot, rsp_valid, rsp_rdata, rsp_err, rsp_timeout and the wait counter all go to 0.
  - A transfer in flight is abandoned with no response.
  - cmd_ready is 0 while preset=1.
- States:
  - IDLE: psel=0, penable=0.
  - SETUP: psel=1, penable=0.
  - ACCESS: psel=1, penable=1.
- cmd_ready = (state==IDLE) || (state==ACCESS && done), where done = pready || tmo_hit.
- Command accept (cmd_valid && cmd_ready):
  - Capture cmd_* into the bus registers.
  - Next state is SETUP.
- Capture rules:
  - pwdata/pstrb take cmd_wdata/cmd_strb on writes.
  - pwdata/pstrb are 0 on reads.
- paddr, pwrite, pwdata, pstrb and pprot are stable from SETUP through the final ACCESS cycle.
- Transitions:
  - IDLE -> SETUP on accept; otherwise stay in IDLE.
  - SETUP -> ACCESS unconditionally.
  - ACCESS with done and accept -> SETUP: back-to-back, psel stays 1 and penable drops for one cycle.
  - ACCESS with done and no accept -> IDLE: all bus registers clear to 0.
  - ACCESS with !done -> stay in ACCESS; wait counter increments.
- Timeout:
  - tmo_hit = (TIMEOUT!=0) && pready==0 && wait counter == TIMEOUT-1, i.e. the TIMEOUT-th consecutive ACCESS cycle with pready low.
  - The wait counter is $clog2(TIMEOUT+1) bits and clears on entry to SETUP.
  - If pready and tmo_hit would coincide, pready wins: normal completion.
- Response, registered on the cycle after the completing ACCESS cycle:
  - rsp_valid=1 for exactly one cycle.
  - Read with pready: rsp_rdata = prdata, rsp_err = pslverr.
  - Write with pready: rsp_rdata = 0, rsp_err = pslverr.
  - Timeout: rsp_rdata = 0, rsp_err = 1, rsp_timeout = 1.
  - pslverr and prdata are sampled only when psel && penable && pready.
  - rsp_* fields are 0 whenever rsp_valid=0.
- Latency with zero wait states:
  - Accept at cycle 0, SETUP at 1, ACCESS at 2, rsp_valid at 3.
  - Back-to-back throughput is one transfer per 2 cycles.
- There is no response backpressure; the consumer must take every rsp_valid pulse.

Decomposition:
- Package apb_pkg holds:
  - State enum apb_state_t {IDLE=2'b00, SETUP=2'b01, ACCESS=2'b10}.
  - pprot bit constants PPROT_PRIV, PPROT_NSEC, PPROT_INSTR.
- One sub-module, apb_wait_timer, with ports (pclk, preset, clr, en, hit) and parameter TIMEOUT. It holds the wait counter and tmo_hit logic.
- The FSM, bus registers and response registers stay in apb_master_gen.

Test Plan:
- Write, zero wait states:
  - Stimulus: cmd_write=1, addr=0x3C, wdata=0xDEADBEEF, strb=4'b0101, prot=3'b010; pready=1 in ACCESS.
  - Response: SETUP at cycle 1, ACCESS at 2 with pstrb=0101 and pprot=010; rsp_valid at 3 with rsp_err=0 and rsp_rdata=0; back to IDLE.
- Read with 3 wait states:
  - Stimulus: addr=0x10; pready low for 3 ACCESS cycles, then high with prdata=0x12345678.
  - Response: penable high for 4 cycles; rsp_rdata=0x12345678 one cycle after pready.
- Back-to-back:
  - Stimulus: cmd_valid held with write then read; pready=1 each ACCESS.
  - Response: psel stays high across both transfers; sequence SETUP, ACCESS, SETUP, ACCESS; two rsp_valid pulses 2 cycles apart.
- Slave error:
  - Stimulus: read with pslverr=1 and pready=1.
  - Response: rsp_err=1, rsp_timeout=0.
- Timeout:
  - Stimulus: TIMEOUT=4, pready held low.
  - Response: abort on the 4th ACCESS cycle; rsp_err=1, rsp_timeout=1, rsp_rdata=0; psel drops. With pready=1 on the 4th cycle instead: normal completion, rsp_timeout=0.
- Reset mid-transfer:
  - Stimulus: preset=1 during ACCESS with pready low.
  - Response: next edge gives psel=0, penable=0, all outputs 0, no rsp_valid; a new command after reset completes normally.

Source files
------------

// File: rtl/apb_pkg.sv
// ----------------------------------------------------------------------------
// apb_pkg
// Shared types and constants for the parametrised APB4 master.
//   apb_state_t  : bus-phase state encoding (IDLE / SETUP / ACCESS)
//   PPROT_*      : bit positions inside the 3-bit pprot field
//   wait_cnt_w() : width of the wait-state counter for a given TIMEOUT
// ----------------------------------------------------------------------------
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SETUP  = 2'b01,
        ACCESS = 2'b10
    } apb_state_t;

    // pprot bit positions
    localparam int PPROT_PRIV  = 0;
    localparam int PPROT_NSEC  = 1;
    localparam int PPROT_INSTR = 2;

    // The counter must be able to hold TIMEOUT-1. A disabled timeout
    // (TIMEOUT == 0) still gets a 1-bit counter so the vector is never empty.
    function automatic int wait_cnt_w(input int timeout);
        if (timeout > 0) begin
            return $clog2(timeout + 1);
        end
        return 1;
    endfunction

endpackage

// File: rtl/apb_wait_timer.sv
// ----------------------------------------------------------------------------
// apb_wait_timer
// Counts consecutive ACCESS cycles with pready low and flags the cycle on
// which the transfer must be aborted.
//   pclk   in  clock, rising edge
//   preset in  synchronous active-high reset
//   clr    in  clear the counter (transfer entering SETUP)
//   en     in  current cycle is ACCESS with pready low
//   hit    out this is the TIMEOUT-th consecutive waited ACCESS cycle
// ----------------------------------------------------------------------------
module apb_wait_timer
    import apb_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic pclk,
    input  logic preset,
    input  logic clr,
    input  logic en,
    output logic hit
);

    localparam int CW = wait_cnt_w(TIMEOUT);
    localparam logic [CW-1:0] LAST = CW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
    localparam logic TMO_ON = (TIMEOUT != 0);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Only qualified by en, so a late pready on the last allowed cycle
    // never raises hit and the slave wins the race.
    assign hit = TMO_ON && en && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && !hit && TMO_ON) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/apb_master_gen.sv
// ----------------------------------------------------------------------------
// apb_master_gen
// Parametrised APB4 master. Commands arrive on a valid/ready channel, are
// registered, and then driven onto the APB bus purely from flops. Each
// completed transfer produces a one-cycle response pulse.
//
// Ports
//   pclk, preset           clock / synchronous active-high reset
//   cmd_valid/cmd_ready    command handshake
//   cmd_write, cmd_addr, cmd_wdata, cmd_strb, cmd_prot  command fields
//   rsp_valid              one-cycle completion pulse
//   rsp_rdata/err/timeout  completion status (all 0 when rsp_valid is 0)
//   psel..pprot            APB request outputs
//   pready, prdata, pslverr APB slave inputs
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | no transfer; psel=0, penable=0; ready for a command
// SETUP  | first bus cycle; psel=1, penable=0
// ACCESS | psel=1, penable=1; waits for pready or the wait-state timeout
// ----------------------------------------------------------------------------
module apb_master_gen
    import apb_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                  pclk,
    input  logic                  preset,

    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_W-1:0]     cmd_addr,
    input  logic [DATA_W-1:0]     cmd_wdata,
    input  logic [DATA_W/8-1:0]   cmd_strb,
    input  logic [2:0]            cmd_prot,

    output logic                  rsp_valid,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_timeout,

    output logic                  psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [ADDR_W-1:0]     paddr,
    output logic [DATA_W-1:0]     pwdata,
    output logic [DATA_W/8-1:0]   pstrb,
    output logic [2:0]            pprot,
    input  logic                  pready,
    input  logic [DATA_W-1:0]     prdata,
    input  logic                  pslverr
);

    localparam int SW = DATA_W / 8;

    apb_state_t          state_q,       state_d;
    logic                psel_q,        psel_d;
    logic                penable_q,     penable_d;
    logic                pwrite_q,      pwrite_d;
    logic [ADDR_W-1:0]   paddr_q,       paddr_d;
    logic [DATA_W-1:0]   pwdata_q,      pwdata_d;
    logic [SW-1:0]       pstrb_q,       pstrb_d;
    logic [2:0]          pprot_q,       pprot_d;
    logic                rsp_valid_q,   rsp_valid_d;
    logic [DATA_W-1:0]   rsp_rdata_q,   rsp_rdata_d;
    logic                rsp_err_q,     rsp_err_d;
    logic                rsp_timeout_q, rsp_timeout_d;

    logic in_access;
    logic tmo_hit;
    logic done;
    logic accept;

    assign in_access = (state_q == ACCESS);
    assign done      = in_access && (pready || tmo_hit);
    assign cmd_ready = !preset && ((state_q == IDLE) || done);
    assign accept    = cmd_valid && cmd_ready;

    apb_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .pclk   (pclk),
        .preset (preset),
        .clr    (accept),
        .en     (in_access && !pready),
        .hit    (tmo_hit)
    );

    always_comb begin
        state_d       = state_q;
        pwrite_d      = pwrite_q;
        paddr_d       = paddr_q;
        pwdata_d      = pwdata_q;
        pstrb_d       = pstrb_q;
        pprot_d       = pprot_q;
        rsp_valid_d   = 1'b0;
        rsp_rdata_d   = '0;
        rsp_err_d     = 1'b0;
        rsp_timeout_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = SETUP;
                end
            end
            SETUP: begin
                state_d = ACCESS;
            end
            ACCESS: begin
                if (done) begin
                    rsp_valid_d = 1'b1;
                    if (pready) begin
                        rsp_err_d   = pslverr;
                        rsp_rdata_d = pwrite_q ? '0 : prdata;
                    end else begin
                        rsp_err_d     = 1'b1;
                        rsp_timeout_d = 1'b1;
                    end
                    if (accept) begin
                        state_d = SETUP;
                    end else begin
                        state_d  = IDLE;
                        pwrite_d = 1'b0;
                        paddr_d  = '0;
                        pwdata_d = '0;
                        pstrb_d  = '0;
                        pprot_d  = '0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Reads carry no write payload so the bus never shows stale data.
        if (accept) begin
            pwrite_d = cmd_write;
            paddr_d  = cmd_addr;
            pprot_d  = cmd_prot;
            pwdata_d = cmd_write ? cmd_wdata : '0;
            pstrb_d  = cmd_write ? cmd_strb  : '0;
        end

        psel_d    = (state_d != IDLE);
        penable_d = (state_d == ACCESS);
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            state_q       <= IDLE;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            pstrb_q       <= '0;
            pprot_q       <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            pwrite_q      <= pwrite_d;
            paddr_q       <= paddr_d;
            pwdata_q      <= pwdata_d;
            pstrb_q       <= pstrb_d;
            pprot_q       <= pprot_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign psel        = psel_q;
    assign penable     = penable_q;
    assign pwrite      = pwrite_q;
    assign paddr       = paddr_q;
    assign pwdata      = pwdata_q;
    assign pstrb       = pstrb_q;
    assign pprot       = pprot_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_master_gen.sv
// ----------------------------------------------------------------------------
// tb_apb_master_gen
// Scoreboard bench for apb_master_gen (TIMEOUT=4). Expected responses are
// queued when a command is accepted and compared when rsp_valid pulses.
// ----------------------------------------------------------------------------
module tb_apb_master_gen;

    localparam int AW  = 8;
    localparam int DW  = 32;
    localparam int TMO = 4;
    localparam int SW  = DW / 8;

    logic          pclk;
    logic          preset;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic [SW-1:0] cmd_strb;
    logic [2:0]    cmd_prot;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          rsp_timeout;
    logic          psel;
    logic          penable;
    logic          pwrite;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic [SW-1:0] pstrb;
    logic [2:0]    pprot;
    logic          pready;
    logic [DW-1:0] prdata;
    logic          pslverr;

    apb_master_gen #(
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .TIMEOUT (TMO)
    ) dut (
        .pclk        (pclk),
        .preset      (preset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .cmd_strb    (cmd_strb),
        .cmd_prot    (cmd_prot),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .rsp_timeout (rsp_timeout),
        .psel        (psel),
        .penable     (penable),
        .pwrite      (pwrite),
        .paddr       (paddr),
        .pwdata      (pwdata),
        .pstrb       (pstrb),
        .pprot       (pprot),
        .pready      (pready),
        .prdata      (prdata),
        .pslverr     (pslverr)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    typedef struct {
        logic [DW-1:0] rdata;
        logic          err;
        logic          tmo;
        int            lat;
        int            acc_cyc;
    } exp_t;

    exp_t          sb[$];
    int            n_cmp = 0;
    int            n_err = 0;
    int            cyc = 0;
    int            acc_cnt = 0;
    int            wait_n = 0;
    int            pen_cnt = 0;
    int            psel_low_cnt = 0;
    int            last_rsp_cyc = 0;
    int            prev_rsp_cyc = 0;
    logic [DW-1:0] rd_val = '0;
    logic          err_val = 1'b0;
    bit            accepted = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock: record an accept, advance, model the slave, check responses.
    task automatic tick();
        exp_t e;
        accepted = 1'b0;
        if (cmd_valid && cmd_ready) begin
            accepted  = 1'b1;
            e.tmo     = (wait_n >= TMO);
            e.rdata   = (cmd_write || e.tmo) ? '0 : rd_val;
            e.err     = e.tmo ? 1'b1 : err_val;
            e.lat     = 3 + (e.tmo ? TMO - 1 : wait_n);
            e.acc_cyc = cyc;
            sb.push_back(e);
        end
        @(posedge pclk);
        #1;
        cyc++;
        if (!psel) psel_low_cnt++;
        if (psel && penable) begin
            pen_cnt++;
            pready  = (acc_cnt >= wait_n);
            prdata  = pready ? rd_val : DW'($urandom);
            pslverr = pready ? err_val : 1'b1;
            acc_cnt++;
        end else begin
            acc_cnt = 0;
            pready  = 1'($urandom_range(0, 1));
            prdata  = DW'($urandom);
            pslverr = 1'($urandom_range(0, 1));
        end
        #1;
        if (rsp_valid) begin
            if (sb.size() == 0) begin
                chk("spurious_rsp", 64'(rsp_valid), 64'd0);
            end else begin
                e = sb.pop_front();
                chk("rsp_rdata",   64'(rsp_rdata),   64'(e.rdata));
                chk("rsp_err",     64'(rsp_err),     64'(e.err));
                chk("rsp_timeout", 64'(rsp_timeout), 64'(e.tmo));
                chk("rsp_latency", 64'(cyc - e.acc_cyc), 64'(e.lat));
            end
            prev_rsp_cyc = last_rsp_cyc;
            last_rsp_cyc = cyc;
        end else begin
            chk("rsp_idle_zero", 64'({rsp_rdata, rsp_err, rsp_timeout}), 64'd0);
        end
    endtask

    // Present a command and hold it until accepted; leaves cmd_valid high.
    task automatic send(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [SW-1:0] s, input logic [2:0] p);
        int n;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        cmd_strb  = s;
        cmd_prot  = p;
        cmd_valid = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!accepted && n < 50);
        if (!accepted) begin
            chk("accept_bound", 64'd0, 64'd1);
        end else begin
            chk("setup_psel",    64'(psel),    64'd1);
            chk("setup_penable", 64'(penable), 64'd0);
            chk("setup_pwrite",  64'(pwrite),  64'(w));
            chk("setup_paddr",   64'(paddr),   64'(a));
            chk("setup_pwdata",  64'(pwdata),  w ? 64'(d) : 64'd0);
            chk("setup_pstrb",   64'(pstrb),   w ? 64'(s) : 64'd0);
            chk("setup_pprot",   64'(pprot),   64'(p));
        end
    endtask

    task automatic drain();
        int n;
        cmd_valid = 1'b0;
        n = 0;
        while (sb.size() != 0 && n < 60) begin
            tick();
            n++;
        end
        chk("drain_bound", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        preset    = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        cmd_strb  = '0;
        cmd_prot  = '0;
        pready    = 1'b0;
        prdata    = '0;
        pslverr   = 1'b0;

        // Reset state
        repeat (3) tick();
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
        chk("rst_bus", 64'({psel, penable, pwrite, paddr, pstrb, pprot}), 64'd0);
        chk("rst_pwdata", 64'(pwdata), 64'd0);
        preset = 1'b0;
        tick();
        chk("idle_cmd_ready", 64'(cmd_ready), 64'd1);

        // Write, zero wait states
        wait_n = 0; err_val = 1'b0;
        send(1'b1, 8'h3C, 32'hDEADBEEF, 4'b0101, 3'b010);
        cmd_valid = 1'b0;
        tick();
        chk("wr_access_psel",    64'(psel),    64'd1);
        chk("wr_access_penable", 64'(penable), 64'd1);
        chk("wr_access_pstrb",   64'(pstrb),   64'h5);
        chk("wr_access_pprot",   64'(pprot),   64'h2);
        chk("wr_access_pwdata",  64'(pwdata),  64'hDEADBEEF);
        tick();
        chk("wr_rsp_seen", 64'(rsp_valid), 64'd1);
        chk("wr_idle_psel",  64'(psel),  64'd0);
        chk("wr_idle_paddr", 64'(paddr), 64'd0);
        chk("wr_idle_pwdata", 64'(pwdata), 64'd0);

        // Read with 3 wait states
        wait_n = 3; rd_val = 32'h12345678;
        pen_cnt = 0;
        send(1'b0, 8'h10, 32'hFFFF_0000, 4'hF, 3'b000);
        drain();
        chk("rd_penable_cycles", 64'(pen_cnt), 64'd4);

        // Back-to-back write then read
        wait_n = 0; rd_val = 32'hA5A5_0001;
        send(1'b1, 8'h20, 32'h0BAD_F00D, 4'b1111, 3'b001);
        psel_low_cnt = 0;
        send(1'b0, 8'h24, 32'h0, 4'h0, 3'b100);
        chk("b2b_psel_held", 64'(psel_low_cnt), 64'd0);
        drain();
        chk("b2b_rsp_gap", 64'(last_rsp_cyc - prev_rsp_cyc), 64'd2);

        // Slave error on read
        wait_n = 1; err_val = 1'b1; rd_val = 32'h0000_BEEF;
        send(1'b0, 8'h44, 32'h0, 4'h0, 3'b000);
        drain();
        err_val = 1'b0;

        // Timeout: pready never arrives
        wait_n = 100;
        send(1'b0, 8'h50, 32'h0, 4'h0, 3'b011);
        drain();
        chk("tmo_psel_drop", 64'(psel), 64'd0);

        // Boundary: pready on the 4th ACCESS cycle completes normally
        wait_n = 3; rd_val = 32'hCAFE_0004;
        send(1'b0, 8'h54, 32'h0, 4'h0, 3'b000);
        drain();

        // Reset mid-transfer
        wait_n = 100;
        send(1'b0, 8'h60, 32'h0, 4'h0, 3'b111);
        cmd_valid = 1'b0;
        tick();
        tick();
        chk("pre_rst_in_access", 64'(penable), 64'd1);
        preset = 1'b1;
        tick();
        sb.delete();
        chk("mid_rst_bus", 64'({psel, penable, pwrite, paddr, pstrb, pprot}), 64'd0);
        chk("mid_rst_pwdata", 64'(pwdata), 64'd0);
        chk("mid_rst_cmd_ready", 64'(cmd_ready), 64'd0);
        preset = 1'b0;
        repeat (8) tick();
        wait_n = 0;
        send(1'b1, 8'h64, 32'h1357_9BDF, 4'b0011, 3'b000);
        drain();

        // Random isolated transfers
        for (int i = 0; i < 8; i++) begin
            wait_n  = $urandom_range(0, 5);
            err_val = 1'($urandom_range(0, 1));
            rd_val  = DW'($urandom);
            send(1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom),
                 SW'($urandom), 3'($urandom));
            drain();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

endmodule
